uart_rx_param: RTL

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// UART receiver with 3-sample majority voting, optional parity, 1/2 stop bits
// and an AXI-Stream output FIFO that drops whole frames on overrun.
module uart_rx_param #(
  parameter int CLOCK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                              m_axis_aclk,
  input  logic                              m_axis_areset,
  input  logic                              rx_bit,
  output logic                              m_axis_tvalid,
  output logic [DATA_BITS-1:0]              m_axis_tdata,
  output logic [1:0]                        m_axis_tuser,
  input  logic                              m_axis_tready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overrun
);

  localparam int UART_CYCLES = CLOCK_FREQ_HZ / BAUD_RATE;
  localparam int HALF        = UART_CYCLES / 2;
  localparam int CW          = $clog2(UART_CYCLES);
  localparam int BW          = $clog2(DATA_BITS);
  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int NW          = $clog2(FIFO_DEPTH + 1);
  localparam int EW          = DATA_BITS + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t                state, state_nxt;
  logic                  rx_meta, rx_s;
  logic [CW-1:0]         cnt;
  logic                  smp_a, smp_b;
  logic                  vote, vote_now, bit_end;
  logic [BW-1:0]         bit_idx;
  logic                  stop_idx;
  logic                  last_stop;
  logic [DATA_BITS-1:0]  shreg;
  logic                  frame_err, par_err, frame_err_now, par_x;
  logic                  push;

  // NOTE: the synchroniser resets to the idle-high line level so that leaving
  // reset never looks like a start bit.
  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_bit;
      rx_s    <= rx_meta;
    end
  end

  assign bit_end       = (cnt == CW'(UART_CYCLES - 1));
  assign vote_now      = (cnt == CW'(HALF + 1));
  assign vote          = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
  assign last_stop     = (stop_idx == 1'(STOP_BITS - 1));
  assign frame_err_now = frame_err | ~vote;
  assign par_x         = (^shreg) ^ vote;

  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) state <= S_IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      S_IDLE:      if (!rx_s) state_nxt = S_START;
      S_START: begin
        if (vote_now && vote) state_nxt = S_IDLE;
        else if (bit_end)     state_nxt = S_DATA;
      end
      S_DATA: begin
        if (bit_end && bit_idx == BW'(DATA_BITS - 1))
          state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY:    if (bit_end) state_nxt = S_STOP;
      S_STOP: begin
        // The frame is pushed mid-way through the last stop bit so the
        // receiver is already hunting for the next start edge.
        if (vote_now && last_stop) begin
          push      = 1'b1;
          state_nxt = frame_err_now ? S_WAIT_IDLE : S_IDLE;
        end
      end
      S_WAIT_IDLE: if (rx_s) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      cnt       <= '0;
      smp_a     <= 1'b1;
      smp_b     <= 1'b1;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      frame_err <= 1'b0;
      par_err   <= 1'b0;
    end else begin
      if (state == S_IDLE)                                       cnt <= rx_s ? '0 : CW'(1);
      else if (state_nxt == S_IDLE || state_nxt == S_WAIT_IDLE) cnt <= '0;
      else if (bit_end)                                          cnt <= '0;
      else                                                       cnt <= cnt + 1'b1;

      if (cnt == CW'(HALF - 1)) smp_a <= rx_s;
      if (cnt == CW'(HALF))     smp_b <= rx_s;

      case (state)
        S_IDLE: begin
          bit_idx   <= '0;
          stop_idx  <= 1'b0;
          frame_err <= 1'b0;
          par_err   <= 1'b0;
        end
        S_DATA: begin
          if (vote_now) shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (bit_end)  bit_idx <= (bit_idx == BW'(DATA_BITS - 1)) ? '0 : bit_idx + 1'b1;
        end
        S_PARITY: begin
          if (vote_now) par_err <= (PARITY == 1) ? ~par_x : par_x;
        end
        S_STOP: begin
          if (vote_now && !vote)      frame_err <= 1'b1;
          if (bit_end && !last_stop)  stop_idx  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output FIFO
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [NW-1:0] count;
  logic          full, pop, wr_en;

  assign full    = (count == NW'(FIFO_DEPTH));
  assign pop     = m_axis_tvalid & m_axis_tready;
  assign wr_en   = push & (~full | pop);
  assign overrun = push & full & ~pop;

  // NOTE: storage is deliberately not reset; the read port is gated by
  // tvalid so stale entries never reach tdata/tuser.
  always_ff @(posedge m_axis_aclk) begin
    if (wr_en) mem[wptr] <= {par_err, frame_err_now, shreg};
  end

  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign m_axis_tvalid = (count != '0);
  assign fifo_count    = count;
  assign {m_axis_tuser, m_axis_tdata} = m_axis_tvalid ? mem[rptr] : '0;

endmodule
